order_manager: RTL

ORDER_MANAGER -- requirements
Module: order_manager

---
 rtl/order_pkg.sv | 21 ++
 rtl/order_fifo.sv | 60 ++++++
 rtl/order_manager.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/order_pkg.sv
// Shared types for the order manager.
//   SIDE_BUY / SIDE_SELL : encoding of order_side
//   order_t              : one queued order {side, price}
//   om_state_t           : order-offer FSM states
package order_pkg;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef struct packed {
    logic       side;
    logic [7:0] price;
  } order_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_COOL  = 2'd2
  } om_state_t;

endpackage

// File: rtl/order_fifo.sv
// Pending-order queue: synchronous FIFO, DEPTH must be a power of two.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count cleared)
//   push, wdata  : write request and data (ignored while full)
//   pop          : read request (ignored while empty)
//   head         : oldest entry, valid whenever empty=0
//   full, empty  : occupancy flags from the registered count
// A push and a pop in the same cycle are both honoured.
module order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until the count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/order_manager.sv
// Order manager: turns buy/sell pulses into orders offered to a gateway.
// Qualifying pulses are queued with the sampled price; an FSM offers the
// queue head (valid/ready), updates the net position on each accepted order
// and then idles for COOLDOWN cycles.
// Handshake: order_valid is high only in OFFER and does not drop until
// order_ready is seen high on a rising edge; side/price are stable meanwhile.
// An order transfers on every edge where order_valid && order_ready.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   price_in                  : price captured with each signal
//   buy_signal, sell_signal   : one-cycle pulses (both high = no event)
//   order_valid/order_ready   : offer handshake
//   order_side, order_price   : offered order (0 when not offering)
//   position                  : signed net position of accepted orders
//   orders_sent               : accepted orders (wraps)
//   dropped_count             : rejected signals (saturates)
// Build option: define RISK_LIMIT_EN to reject signals that would push the
// projected position beyond +/-MAX_POS. FSM state is visible as `state`.
module order_manager
  import order_pkg::*;
#(
  parameter int MAX_POS    = 4,
  parameter int COOLDOWN   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        price_in,
  input  logic              buy_signal,
  input  logic              sell_signal,
  output logic              order_valid,
  input  logic              order_ready,
  output logic              order_side,
  output logic [7:0]        order_price,
  output logic signed [7:0] position,
  output logic [15:0]       orders_sent,
  output logic [15:0]       dropped_count
);

`ifdef RISK_LIMIT_EN
  localparam bit RISK_EN = 1'b1;
`else
  localparam bit RISK_EN = 1'b0;
`endif

  localparam logic signed [7:0] MAX_S = MAX_POS[7:0];
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] COOL_INIT = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;

  om_state_t         state, state_next;
  logic [CW-1:0]     cool_cnt, cool_cnt_next;
  logic signed [7:0] projected;
  logic              buy_ev, sell_ev, risk_block, accept, drop, pop;
  logic              fifo_full, fifo_empty;
  order_t            push_data, head;

  // Simultaneous buy and sell cancel out entirely.
  assign buy_ev  = buy_signal && !sell_signal;
  assign sell_ev = sell_signal && !buy_signal;

  // The projected position already includes every queued order, so the limit
  // holds even if the whole queue is eventually accepted.
  assign risk_block = RISK_EN && ((buy_ev && (projected >= MAX_S)) ||
                                  (sell_ev && (projected <= -MAX_S)));
  // Full is the pre-edge flag: a pop in this cycle does not make room.
  assign accept = (buy_ev || sell_ev) && !fifo_full && !risk_block;
  assign drop   = (buy_ev || sell_ev) && !accept;

  assign push_data.side  = buy_ev ? SIDE_BUY : SIDE_SELL;
  assign push_data.price = price_in;

  order_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(order_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .wdata (push_data),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cool_cnt <= '0;
    end else begin
      state    <= state_next;
      cool_cnt <= cool_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    cool_cnt_next = cool_cnt;
    pop           = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) state_next = ST_OFFER;
      ST_OFFER: begin
        if (order_ready) begin
          pop = 1'b1;
          if (COOLDOWN == 0) begin
            state_next = ST_IDLE;
          end else begin
            state_next    = ST_COOL;
            cool_cnt_next = COOL_INIT;
          end
        end
      end
      ST_COOL: begin
        if (cool_cnt == '0) state_next = ST_IDLE;
        else                cool_cnt_next = cool_cnt - CW'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign order_valid = (state == ST_OFFER);
  assign order_side  = order_valid ? head.side  : 1'b0;
  assign order_price = order_valid ? head.price : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position      <= '0;
      projected     <= '0;
      orders_sent   <= '0;
      dropped_count <= '0;
    end else begin
      if (pop) begin
        position    <= (head.side == SIDE_BUY) ? position + 8'sd1 : position - 8'sd1;
        orders_sent <= orders_sent + 16'd1;
      end
      if (accept) projected <= buy_ev ? projected + 8'sd1 : projected - 8'sd1;
      if (drop && (dropped_count != 16'hFFFF)) dropped_count <= dropped_count + 16'd1;
    end
  end

endmodule
